axis_frame_gen: RTL and testbench

AXI4-Stream video frame generator: a master source that produces raster frames of programmable width and height, marking start-of-frame on tuser and end-of-line on tlast. It drives the slave side of the stream pass-through interface as a stimulus and bring-up source. It also acts as a test-pattern replacement for a camera input. Output beats are fully registered, honour tready backpressure, and sustain one pixel per clock.

---
 rtl/axis_frame_gen_pkg.sv | 24 ++
 rtl/axis_frame_gen_if.sv | 26 ++
 rtl/axis_frame_cnt.sv | 63 ++++++
 rtl/axis_frame_gen.sv | 135 +++++++++++++
 tb/tb_axis_frame_gen.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_frame_gen_pkg.sv
// rtl/axis_frame_gen_pkg.sv - shared types, defaults and pixel packing for the frame generator
package axis_frame_gen_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int C_DIM_W_DEFAULT = 12;

    // Bit offsets of the x and y coordinate fields inside tdata
    localparam int X_LSB = 0;
    localparam int Y_LSB = 16;

    // Places the 16-bit coordinates into their tdata fields
    function automatic logic [31:0] pack_xy(input logic [15:0] px, input logic [15:0] py);
        logic [31:0] d;
        d              = '0;
        d[X_LSB +: 16] = px;
        d[Y_LSB +: 16] = py;
        return d;
    endfunction

endpackage

// File: rtl/axis_frame_gen_if.sv
// rtl/axis_frame_gen_if.sv - AXI4-Stream video beat interface with master/slave views
interface axis_frame_gen_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tuser;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/axis_frame_cnt.sv
// rtl/axis_frame_cnt.sv - x/y raster position counter with registered sof/eol/eof flags
module axis_frame_cnt
    import axis_frame_gen_pkg::*;
#(
    parameter int C_DIM_W = C_DIM_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               advance,
    input  logic               clear,
    input  logic [C_DIM_W-1:0] w_q,
    input  logic [C_DIM_W-1:0] h_q,
    output logic [C_DIM_W-1:0] x,
    output logic [C_DIM_W-1:0] y,
    output logic               sof,
    output logic               eol,
    output logic               eof
);

    localparam logic [C_DIM_W-1:0] ONE = C_DIM_W'(1);

    logic [C_DIM_W-1:0] x_inc;
    logic [C_DIM_W-1:0] y_inc;
    logic [C_DIM_W-1:0] w_last;
    logic [C_DIM_W-1:0] h_last;

    assign x_inc  = x + ONE;
    assign y_inc  = y + ONE;
    assign w_last = w_q - ONE;
    assign h_last = h_q - ONE;

    // Flags are computed one step ahead so they are flops aligned with x/y,
    // keeping tuser/tlast free of any combinational compare at the output.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x   <= '0;
            y   <= '0;
            sof <= 1'b0;
            eol <= 1'b0;
            eof <= 1'b0;
        end else if (load) begin
            x   <= '0;
            y   <= '0;
            sof <= 1'b1;
            eol <= (w_q == ONE);
            eof <= (w_q == ONE) && (h_q == ONE);
        end else if (advance) begin
            sof <= 1'b0;
            if (eol) begin
                x   <= '0;
                y   <= y_inc;
                eol <= (w_q == ONE);
                eof <= (w_q == ONE) && (y_inc == h_last);
            end else begin
                x   <= x_inc;
                eol <= (x_inc == w_last);
                eof <= (x_inc == w_last) && (y == h_last);
            end
        end
    end

endmodule

// File: rtl/axis_frame_gen.sv
// rtl/axis_frame_gen.sv - AXI4-Stream raster frame generator top; AXIS_FRAME_GEN_CNT_EN adds frame_count
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_DIM_W              = C_DIM_W_DEFAULT
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               enable,
    input  logic [C_DIM_W-1:0] cfg_width,
    input  logic [C_DIM_W-1:0] cfg_height,
    output logic               busy,
    axis_frame_gen_if.master   m_axis
`ifdef AXIS_FRAME_GEN_CNT_EN
    ,
    output logic [31:0]        frame_count
`endif
);

    state_t                          state;
    logic                            tvalid_q;
    logic                            busy_q;
    logic [C_DIM_W-1:0]              w_q;
    logic [C_DIM_W-1:0]              h_q;
    logic [C_DIM_W-1:0]              w_sel;
    logic [C_DIM_W-1:0]              h_sel;
    logic [C_DIM_W-1:0]              x;
    logic [C_DIM_W-1:0]              y;
    logic                            sof;
    logic                            eol;
    logic                            eof;
    logic                            cfg_ok;
    logic                            hs;
    logic                            eof_hs;
    logic                            start;
    logic                            advance;
    logic                            clear;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata_w;

    assign cfg_ok  = (cfg_width != '0) && (cfg_height != '0);
    assign hs      = tvalid_q & m_axis.tready;
    assign eof_hs  = (state == ACTIVE) && hs && eof;
    // A frame starts from IDLE or directly after the final handshake of the
    // previous frame, which is what gives back-to-back frames with no gap.
    assign start   = enable && cfg_ok && ((state == IDLE) || eof_hs);
    assign advance = (state == ACTIVE) && hs && !eof;
    assign clear   = eof_hs && !start;

    // On a frame start the counter must see the new dimensions in the same
    // cycle they are latched, so it is fed the incoming cfg rather than w_q.
    assign w_sel   = start ? cfg_width  : w_q;
    assign h_sel   = start ? cfg_height : h_q;

    axis_frame_cnt #(
        .C_DIM_W (C_DIM_W)
    ) u_cnt (
        .clk     (aclk),
        .rst     (areset),
        .load    (start),
        .advance (advance),
        .clear   (clear),
        .w_q     (w_sel),
        .h_q     (h_sel),
        .x       (x),
        .y       (y),
        .sof     (sof),
        .eol     (eol),
        .eof     (eof)
    );

    // Frame FSM: owns tvalid/busy and the per-frame dimension latch
    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= IDLE;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            w_q      <= '0;
            h_q      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACTIVE;
                        tvalid_q <= 1'b1;
                        busy_q   <= 1'b1;
                        w_q      <= cfg_width;
                        h_q      <= cfg_height;
                    end
                end
                ACTIVE: begin
                    if (eof_hs) begin
                        if (start) begin
                            w_q <= cfg_width;
                            h_q <= cfg_height;
                        end else begin
                            state    <= IDLE;
                            tvalid_q <= 1'b0;
                            busy_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tvalid_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXIS_FRAME_GEN_CNT_EN
    // Completed-frame counter, wraps naturally at 32 bits
    always_ff @(posedge aclk) begin
        if (areset) begin
            frame_count <= '0;
        end else if (eof_hs) begin
            frame_count <= frame_count + 32'd1;
        end
    end
`endif

    // Pixel payload straight from the registered raster position
    always_comb begin
        tdata_w        = '0;
        tdata_w[31:0]  = pack_xy(16'(x), 16'(y));
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_w;
    assign m_axis.tlast  = eol;
    assign m_axis.tuser  = sof;
    assign busy          = busy_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// tb/tb_axis_frame_gen.sv - randomized self-checking bench with a queue-based frame model
module tb_axis_frame_gen;

    localparam int DW   = 32;
    localparam int DIMW = 12;

    logic            aclk       = 1'b0;
    logic            areset     = 1'b1;
    logic            enable     = 1'b0;
    logic [DIMW-1:0] cfg_width  = '0;
    logic [DIMW-1:0] cfg_height = '0;
    logic            busy;
`ifdef AXIS_FRAME_GEN_CNT_EN
    logic [31:0]     frame_count;
`endif

    axis_frame_gen_if #(.DATA_W(DW)) m_axis_if ();

    axis_frame_gen #(
        .C_M_AXIS_TDATA_WIDTH (DW),
        .C_DIM_W              (DIMW)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .enable      (enable),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .busy        (busy),
        .m_axis      (m_axis_if)
`ifdef AXIS_FRAME_GEN_CNT_EN
        ,
        .frame_count (frame_count)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] data;
        bit          last;
        bit          user;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       log_q[$];
    int unsigned m_frames = 0;
    bit          mdl_on   = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A whole frame is enumerated up front as the list of beats it must produce
    function automatic void push_frame(input int w, input int h);
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                beat_t b;
                b.data = (32'(yy) << 16) | 32'(xx);
                b.last = (xx == w - 1);
                b.user = (xx == 0) && (yy == 0);
                exp_q.push_back(b);
            end
        end
    endfunction

    // Model: pending beats of the current frame; empty queue means idle
    always @(posedge aclk) begin
        if (areset) begin
            exp_q.delete();
            m_frames = 0;
            mdl_on   = 1'b1;
        end else if (mdl_on) begin
            if (exp_q.size() != 0) begin
                if (m_axis_if.tready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        m_frames++;
                        if (enable && cfg_width != 0 && cfg_height != 0)
                            push_frame(int'(cfg_width), int'(cfg_height));
                    end
                end
            end else if (enable && cfg_width != 0 && cfg_height != 0) begin
                push_frame(int'(cfg_width), int'(cfg_height));
            end
        end
    end

    // Compare process: DUT outputs against the model every cycle
    always @(negedge aclk) begin
        if (mdl_on) begin
            bit ev;
            ev = (exp_q.size() != 0);
            chk("tvalid", m_axis_if.tvalid, ev);
            chk("busy", busy, ev);
            if (ev) begin
                chk("tdata", m_axis_if.tdata, exp_q[0].data);
                chk("tlast", m_axis_if.tlast, exp_q[0].last);
                chk("tuser", m_axis_if.tuser, exp_q[0].user);
            end
`ifdef AXIS_FRAME_GEN_CNT_EN
            chk("frame_count", frame_count, m_frames);
`endif
            if (m_axis_if.tvalid === 1'b1 && m_axis_if.tready === 1'b1) begin
                beat_t b;
                b.data = m_axis_if.tdata;
                b.last = m_axis_if.tlast;
                b.user = m_axis_if.tuser;
                log_q.push_back(b);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic pulse_enable();
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int c;
        c = 0;
        while (m_axis_if.tvalid !== 1'b0 && c < 300) begin
            tick(1);
            c++;
        end
        if (c >= 300) chk({nm, "_timeout"}, 1, 0);
    endtask

    initial begin
        m_axis_if.tready = 1'b1;
        areset = 1'b1;
        tick(3);
        chk("rst_tvalid", m_axis_if.tvalid, 0);
        chk("rst_tdata", m_axis_if.tdata, 0);
        chk("rst_tlast", m_axis_if.tlast, 0);
        chk("rst_tuser", m_axis_if.tuser, 0);
        chk("rst_busy", busy, 0);
        areset = 1'b0;
        tick(1);

        // 4x2 frame, tready high, one-cycle enable
        cfg_width = 12'd4; cfg_height = 12'd2;
        log_q.delete();
        pulse_enable();
        tick(12);
        chk("t1_count", log_q.size(), 8);
        chk("t1_d0", log_q[0].data, 32'h0000_0000);
        chk("t1_d3", log_q[3].data, 32'h0000_0003);
        chk("t1_d4", log_q[4].data, 32'h0001_0000);
        chk("t1_d7", log_q[7].data, 32'h0001_0003);
        chk("t1_u0", log_q[0].user, 1);
        chk("t1_u1", log_q[1].user, 0);
        chk("t1_u4", log_q[4].user, 0);
        chk("t1_l2", log_q[2].last, 0);
        chk("t1_l3", log_q[3].last, 1);
        chk("t1_l7", log_q[7].last, 1);
        chk("t1_end_tvalid", m_axis_if.tvalid, 0);
        chk("t1_end_busy", busy, 0);

        // 3x3 frame with tready toggling each cycle
        cfg_width = 12'd3; cfg_height = 12'd3;
        log_q.delete();
        pulse_enable();
        for (int i = 0; i < 30; i++) begin
            m_axis_if.tready = ~m_axis_if.tready;
            tick(1);
        end
        m_axis_if.tready = 1'b1;
        wait_idle("t2");
        chk("t2_count", log_q.size(), 9);
        for (int i = 0; i < 9; i++)
            chk("t2_order", log_q[i].data, ((i / 3) << 16) | (i % 3));

        // 2x2 with enable held: back-to-back frames
        cfg_width = 12'd2; cfg_height = 12'd2;
        log_q.delete();
        enable = 1'b1;
        tick(12);
        enable = 1'b0;
        wait_idle("t3");
        chk("t3_whole_frames", log_q.size() % 4, 0);
        chk("t3_min_beats", log_q.size() >= 12, 1);
        chk("t3_u0", log_q[0].user, 1);
        chk("t3_u1", log_q[1].user, 0);
        chk("t3_u4", log_q[4].user, 1);
        chk("t3_u8", log_q[8].user, 1);
        chk("t3_d4", log_q[4].data, 32'h0000_0000);
        chk("t3_d7", log_q[7].data, 32'h0001_0001);

        // 1x3 column: every beat ends a line
        cfg_width = 12'd1; cfg_height = 12'd3;
        log_q.delete();
        pulse_enable();
        tick(6);
        wait_idle("t4");
        chk("t4_count", log_q.size(), 3);
        chk("t4_l0", log_q[0].last, 1);
        chk("t4_l1", log_q[1].last, 1);
        chk("t4_l2", log_q[2].last, 1);
        chk("t4_u0", log_q[0].user, 1);
        chk("t4_u2", log_q[2].user, 0);
        chk("t4_d2", log_q[2].data, 32'h0002_0000);

        // 4x4 frame abandoned by reset after 5 beats
        cfg_width = 12'd4; cfg_height = 12'd4;
        log_q.delete();
        pulse_enable();
        tick(4);
        areset = 1'b1;
        tick(1);
        chk("t5_tvalid", m_axis_if.tvalid, 0);
        chk("t5_tdata", m_axis_if.tdata, 0);
        chk("t5_tlast", m_axis_if.tlast, 0);
        chk("t5_tuser", m_axis_if.tuser, 0);
        chk("t5_busy", busy, 0);
        chk("t5_beats", log_q.size(), 5);
        areset = 1'b0;
        tick(1);
        pulse_enable();
        chk("t5_new_tvalid", m_axis_if.tvalid, 1);
        chk("t5_new_tdata", m_axis_if.tdata, 0);
        chk("t5_new_tuser", m_axis_if.tuser, 1);
        wait_idle("t5");

        // Zero width: nothing emitted
        cfg_width = 12'd0; cfg_height = 12'd3;
        enable = 1'b1;
        tick(10);
        chk("t6_tvalid", m_axis_if.tvalid, 0);
        chk("t6_busy", busy, 0);
        enable = 1'b0;
        tick(2);

        // Randomized traffic: backpressure, cfg churn, enable flips, rare reset
        for (int i = 0; i < 4000; i++) begin
            m_axis_if.tready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                cfg_width  = 12'($urandom_range(0, 5));
                cfg_height = 12'($urandom_range(0, 5));
            end
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            areset = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        areset = 1'b0;
        enable = 1'b0;
        m_axis_if.tready = 1'b1;
        wait_idle("rand");
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
